// File: rtl/ysyx_23060025_scoreboard.sv
// GPR/CSR write scoreboard between IDU issue and WBU retirement: per-register
// in-flight writer counters, issue stall generation, stall counter, underflow flag.
module ysyx_23060025_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        idu_valid_i,
    input  logic        idu_ren1_i,
    input  logic [4:0]  idu_rsc1_i,
    input  logic        idu_ren2_i,
    input  logic [4:0]  idu_rsc2_i,
    input  logic        idu_wd_i,
    input  logic [4:0]  idu_wreg_i,
    input  logic        idu_csr_ren_i,
    input  logic        idu_csr_wen_i,
    input  logic        exu_allowin_i,
    input  logic        wbu_valid_i,
    input  logic        wbu_wd_i,
    input  logic [4:0]  wbu_wreg_i,
    input  logic        wbu_csr_wen_i,
    input  logic        flush_i,
    output logic        sb_stall_o,
    output logic        sb_issue_o,
    output logic [31:0] sb_pending_o,
    output logic        sb_csr_pending_o,
    output logic [31:0] sb_stall_cnt_o,
    output logic        sb_err_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [0:31];
    logic [CNT_W-1:0] cnt_d [0:31];
    logic [CNT_W-1:0] csr_cnt_q, csr_cnt_d;
    logic [31:0]      stall_cnt_q;
    logic             err_q;
    logic [31:0]      inc_w, dec_w;
    logic             csr_inc, csr_dec;
    logic             gpr_under, csr_under;
    logic             raw1, raw2, csr_haz, sat, csat;

    // Hazards look only at registered counts; a same-cycle retire never releases a stall.
    assign raw1    = idu_ren1_i && (idu_rsc1_i != 5'd0) && (cnt_q[idu_rsc1_i] != '0);
    assign raw2    = idu_ren2_i && (idu_rsc2_i != 5'd0) && (cnt_q[idu_rsc2_i] != '0);
    assign csr_haz = idu_csr_ren_i && (csr_cnt_q != '0);
    assign sat     = idu_wd_i && (idu_wreg_i != 5'd0) && (cnt_q[idu_wreg_i] == CNT_MAX);
    assign csat    = idu_csr_wen_i && (csr_cnt_q == CNT_MAX);

    assign sb_stall_o = idu_valid_i && (raw1 || raw2 || csr_haz || sat || csat);
    assign sb_issue_o = idu_valid_i && exu_allowin_i && !sb_stall_o;

    assign inc_w[0]        = 1'b0;
    assign dec_w[0]        = 1'b0;
    assign sb_pending_o[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            assign inc_w[gi]        = sb_issue_o && idu_wd_i && (idu_wreg_i == 5'(gi));
            assign dec_w[gi]        = wbu_valid_i && wbu_wd_i && (wbu_wreg_i == 5'(gi));
            assign sb_pending_o[gi] = (cnt_q[gi] != '0);
        end
    endgenerate

    assign csr_inc = sb_issue_o && idu_csr_wen_i;
    assign csr_dec = wbu_valid_i && wbu_csr_wen_i;

    always_comb begin
        gpr_under = 1'b0;
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_w[r] && !dec_w[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_w[r] && !inc_w[r]) begin
                if (cnt_q[r] == '0) gpr_under = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_comb begin
        csr_cnt_d = csr_cnt_q;
        csr_under = 1'b0;
        if (csr_inc && !csr_dec) begin
            csr_cnt_d = csr_cnt_q + CNT_ONE;
        end else if (csr_dec && !csr_inc) begin
            if (csr_cnt_q == '0) csr_under = 1'b1;
            else                 csr_cnt_d = csr_cnt_q - CNT_ONE;
        end
    end

    // Flush kills all in-flight writers, so it beats any same-cycle issue or retire.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
            csr_cnt_q   <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= flush_i ? '0 : cnt_d[r];
            csr_cnt_q <= flush_i ? '0 : csr_cnt_d;
            if (sb_stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (!flush_i && (gpr_under || csr_under)) err_q <= 1'b1;
        end
    end

    assign sb_csr_pending_o = (csr_cnt_q != '0);
    assign sb_stall_cnt_o   = stall_cnt_q;
    assign sb_err_o         = err_q;
endmodule
